// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants, accumulator sizing and round/saturate helper
package fir_pkg;

  localparam int FIR_DEFAULT_COEF [16] = '{
    -84, -53, 120, 240, 350, 420, 450, 460,
    460, 450, 420, 350, 240, 120, -53, -84
  };

  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Round half up at bit 'shift' (arithmetic shift), then clamp to signed out_w.
  function automatic longint round_sat(input longint sum, input int shift, input int out_w);
    longint rnd;
    longint hi;
    longint lo;
    rnd = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    if (rnd > hi) begin
      return hi;
    end
    if (rnd < lo) begin
      return lo;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/fir_stream_param_if.sv
// rtl/fir_stream_param_if.sv - sample/result handshakes and coefficient port of the streaming FIR
interface fir_stream_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 4,
  parameter int Y_W    = 36
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] sample_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [Y_W-1:0]    y_out;
  logic                     coef_wr_en;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_commit;

  modport slave (
    input  in_valid, sample_in, out_ready, coef_wr_en, coef_addr, coef_wdata, coef_commit,
    output in_ready, out_valid, y_out
  );

  modport master (
    output in_valid, sample_in, out_ready, coef_wr_en, coef_addr, coef_wdata, coef_commit,
    input  in_ready, out_valid, y_out
  );
endinterface

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - double-buffered coefficient bank: shadow writes, atomic commit to active
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS  = 16,
  parameter int COEF_W = 16,
  localparam int AW    = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            addr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic                     commit,
  output logic signed [COEF_W-1:0] active [NTAPS]
);

  logic signed [COEF_W-1:0] shadow [NTAPS];
  logic                     addr_ok;

  // Only the 16-tap build has a meaningful default response; others pass samples through.
  function automatic logic signed [COEF_W-1:0] reset_coef(input int k);
    if (NTAPS == 16) begin
      return COEF_W'(FIR_DEFAULT_COEF[k % 16]);
    end
    return (k == 0) ? COEF_W'(1) : '0;
  endfunction

  assign addr_ok = ({1'b0, addr} < (AW + 1)'(NTAPS));

  // Commit reads shadow before this edge's write lands, so a same-cycle write is not copied.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= reset_coef(k);
        active[k] <= reset_coef(k);
      end
    end else begin
      if (commit) begin
        active <= shadow;
      end
      if (wr_en && addr_ok) begin
        shadow[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/fir_stream_param.sv
// rtl/fir_stream_param.sv - parametrised streaming direct-form FIR; FIR_ROUND_SAT_EN selects rounded/saturated output
module fir_stream_param
  import fir_pkg::*;
#(
  parameter int NTAPS     = 16,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = acc_width(DATA_W, COEF_W, NTAPS),
  parameter int OUT_SHIFT = 11,
  parameter int OUT_W     = 16
) (
  input logic               clk,
  input logic               reset_n,
  fir_stream_param_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;
`ifdef FIR_ROUND_SAT_EN
  localparam int Y_W = OUT_W;
`else
  localparam int Y_W = ACC_W;
`endif

  if (NTAPS < 2 || NTAPS > 64 || OUT_SHIFT < 1 || OUT_W < 2 || ACC_W < PROD_W) begin : g_bad_params
    $error("fir_stream_param: unsupported parameter set");
  end

  logic                     advance;
  logic                     v0;
  logic                     v1;
  logic                     out_valid_r;
  logic signed [DATA_W-1:0] tap  [NTAPS];
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [PROD_W-1:0] prod [NTAPS];
  logic signed [ACC_W-1:0]  sum;
  logic signed [Y_W-1:0]    y_r;

  // The whole pipeline moves as one; it only freezes when a result is waiting downstream.
  assign advance       = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_r;
  assign bus.y_out     = y_r;

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.coef_wr_en),
    .addr    (bus.coef_addr),
    .wdata   (bus.coef_wdata),
    .commit  (bus.coef_commit),
    .active  (coef)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        tap[k] <= '0;
      end
      v0 <= 1'b0;
    end else if (advance) begin
      v0 <= bus.in_valid;
      if (bus.in_valid) begin
        tap[0] <= bus.sample_in;
        for (int k = 1; k < NTAPS; k++) begin
          tap[k] <= tap[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod[k] <= '0;
      end
      v1 <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod[k] <= PROD_W'(coef[k]) * PROD_W'(tap[k]);
      end
      v1 <= v0;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sum = sum + ACC_W'(prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_r         <= '0;
      out_valid_r <= 1'b0;
    end else if (advance) begin
`ifdef FIR_ROUND_SAT_EN
      y_r <= Y_W'(round_sat(64'(sum), OUT_SHIFT, OUT_W));
`else
      y_r <= sum;
`endif
      out_valid_r <= v1;
    end
  end

endmodule
